// File: rtl/z80fi_insn_capture.sv
// Z80FI capture stage: folds the retire-time event stream into one z80fi packet
// per instruction (bytes, length, register snapshots, up to two memory writes).
module z80fi_insn_capture #(
  parameter int MAX_LEN = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 insn_start,
  input  logic                 insn_done,
  input  logic                 fetch_valid,
  input  logic [7:0]           fetch_data,
  input  logic                 mem_wr_valid,
  input  logic [15:0]          mem_wr_addr,
  input  logic [7:0]           mem_wr_data,
  input  logic [15:0]          reg_bc,
  input  logic [15:0]          reg_de,
  input  logic [15:0]          reg_hl,
  input  logic [15:0]          reg_sp,
  input  logic [15:0]          reg_ip,
  output logic                 z80fi_valid,
  output logic [8*MAX_LEN-1:0] z80fi_insn,
  output logic [2:0]           z80fi_insn_len,
  output logic [15:0]          z80fi_reg_bc_in,
  output logic [15:0]          z80fi_reg_de_in,
  output logic [15:0]          z80fi_reg_hl_in,
  output logic [15:0]          z80fi_reg_sp_in,
  output logic [15:0]          z80fi_reg_ip_in,
  output logic [15:0]          z80fi_reg_bc_out,
  output logic [15:0]          z80fi_reg_de_out,
  output logic [15:0]          z80fi_reg_hl_out,
  output logic [15:0]          z80fi_reg_sp_out,
  output logic [15:0]          z80fi_reg_ip_out,
  output logic                 z80fi_mem_wr,
  output logic                 z80fi_mem_wr2,
  output logic [15:0]          z80fi_bus_waddr,
  output logic [7:0]           z80fi_bus_wdata,
  output logic [15:0]          z80fi_bus_waddr2,
  output logic [7:0]           z80fi_bus_wdata2,
  output logic                 z80fi_overflow,
  output logic                 z80fi_abort
);

  localparam int IW = 8 * MAX_LEN;

  typedef enum logic {
    IDLE,
    CAPTURE
  } state_t;

  typedef struct packed {
    logic [15:0] bc;
    logic [15:0] de;
    logic [15:0] hl;
    logic [15:0] sp;
    logic [15:0] ip;
  } regs_t;

  typedef struct packed {
    logic [IW-1:0] bytes;
    logic [2:0]    cnt;
    logic [1:0]    wcnt;
    logic          ovf;
    logic [15:0]   waddr;
    logic [7:0]    wdata;
    logic [15:0]   waddr2;
    logic [7:0]    wdata2;
    regs_t         rin;
  } cap_t;

  state_t state_q, state_d;
  cap_t   cap_q, cap_d, pkt_src;
  regs_t  live_regs;
  logic   emit, abort_d;

  assign live_regs = '{bc: reg_bc, de: reg_de, hl: reg_hl, sp: reg_sp, ip: reg_ip};

  // Next-state and capture update. When insn_start coincides with insn_done, this
  // cycle's fetch/write belong to the new instruction, so the retiring packet is
  // taken from the untouched old capture.
  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    emit    = 1'b0;
    abort_d = 1'b0;

    if (insn_start) begin
      cap_d     = '0;
      cap_d.rin = live_regs;
    end

    if (insn_start || state_q == CAPTURE) begin
      if (fetch_valid) begin
        if (cap_d.cnt < 3'(MAX_LEN)) begin
          for (int k = 0; k < MAX_LEN; k++) begin
            if (cap_d.cnt == 3'(k)) cap_d.bytes[8*k +: 8] = fetch_data;
          end
          cap_d.cnt = cap_d.cnt + 3'd1;
        end else begin
          cap_d.ovf = 1'b1;
        end
      end
      if (mem_wr_valid) begin
        case (cap_d.wcnt)
          2'd0: begin
            cap_d.waddr = mem_wr_addr;
            cap_d.wdata = mem_wr_data;
            cap_d.wcnt  = 2'd1;
          end
          2'd1: begin
            cap_d.waddr2 = mem_wr_addr;
            cap_d.wdata2 = mem_wr_data;
            cap_d.wcnt   = 2'd2;
          end
          default: cap_d.ovf = 1'b1;
        endcase
      end
    end

    pkt_src = insn_start ? cap_q : cap_d;

    case (state_q)
      IDLE: begin
        if (insn_start) state_d = CAPTURE;
      end
      CAPTURE: begin
        emit    = insn_done;
        abort_d = insn_start && !insn_done;
        if (insn_done && !insn_start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  // NOTE: everything, including the byte buffer, is asynchronously cleared because
  // unused slots and unwritten records must read 0 straight out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      z80fi_valid      <= 1'b0;
      z80fi_abort      <= 1'b0;
      z80fi_insn       <= '0;
      z80fi_insn_len   <= '0;
      z80fi_reg_bc_in  <= '0;
      z80fi_reg_de_in  <= '0;
      z80fi_reg_hl_in  <= '0;
      z80fi_reg_sp_in  <= '0;
      z80fi_reg_ip_in  <= '0;
      z80fi_reg_bc_out <= '0;
      z80fi_reg_de_out <= '0;
      z80fi_reg_hl_out <= '0;
      z80fi_reg_sp_out <= '0;
      z80fi_reg_ip_out <= '0;
      z80fi_mem_wr     <= 1'b0;
      z80fi_mem_wr2    <= 1'b0;
      z80fi_bus_waddr  <= '0;
      z80fi_bus_wdata  <= '0;
      z80fi_bus_waddr2 <= '0;
      z80fi_bus_wdata2 <= '0;
      z80fi_overflow   <= 1'b0;
    end else begin
      z80fi_valid <= emit;
      z80fi_abort <= abort_d;
      // Packet fields hold between packets.
      if (emit) begin
        z80fi_insn       <= pkt_src.bytes;
        z80fi_insn_len   <= pkt_src.cnt;
        z80fi_reg_bc_in  <= pkt_src.rin.bc;
        z80fi_reg_de_in  <= pkt_src.rin.de;
        z80fi_reg_hl_in  <= pkt_src.rin.hl;
        z80fi_reg_sp_in  <= pkt_src.rin.sp;
        z80fi_reg_ip_in  <= pkt_src.rin.ip;
        z80fi_reg_bc_out <= live_regs.bc;
        z80fi_reg_de_out <= live_regs.de;
        z80fi_reg_hl_out <= live_regs.hl;
        z80fi_reg_sp_out <= live_regs.sp;
        z80fi_reg_ip_out <= live_regs.ip;
        z80fi_mem_wr     <= pkt_src.wcnt != 2'd0;
        z80fi_mem_wr2    <= pkt_src.wcnt == 2'd2;
        z80fi_bus_waddr  <= pkt_src.waddr;
        z80fi_bus_wdata  <= pkt_src.wdata;
        z80fi_bus_waddr2 <= pkt_src.waddr2;
        z80fi_bus_wdata2 <= pkt_src.wdata2;
        z80fi_overflow   <= pkt_src.ovf;
      end
    end
  end

endmodule
